stage_id: RTL and testbench
===========================

STAGE_ID -- requirements
Module: stage_id

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 flush  input  1  discard the instruction being decoded and empty the output register.
REQ-005 hold  input  1  downstream stall; output register keeps its value.
REQ-006 instruction_valid  input  1  instruction word present this cycle.
REQ-007 instruction  input  32  MIPS instruction word.
REQ-008 instruction_ready  output  1  combinational; the instruction is consumed this cycle.
REQ-009 register_address_a  output  5  register file read address, rs field.
REQ-010 register_address_b  output  5  register file read address, rt field.
REQ-011 register_data_a  input  32  combinational read data for register_address_a.
REQ-012 register_data_b  input  32  combinational read data for register_address_b.
REQ-013 ex_result  input  32  result computed by EX for the instruction currently held in this block's output register.
REQ-014 mem_write_enable, mem_write_address, mem_write_data  input  1/5/32  writeback candidate in MEM.
REQ-015 category  output  3  registered; 0 none, 1 logic, 2 load.
REQ-016 operator  output  8  registered operation code.
REQ-017 operand_a, operand_b  output  32 each  registered operands.
REQ-018 result_address  output  5  registered destination register.
REQ-019 destination_write_enable  output  1  registered; 0 marks a bubble.

Function
REQ-020 Decode SHALL be: SPECIAL funct 100101 OR, 100100 AND, 100110 XOR, 100111 NOR (dest rd, operands rs,rt); opcode 001101 ORI, 001100 ANDI, 001110 XORI (dest rt, operand_b = zero-extended imm16); 001111 LUI (operator OR, operand_a = {imm16,16'h0}, operand_b = 0, dest rt); 100011 LW (category 2, operator 8'h23, operand_a = rs, operand_b = sign-extended imm16, dest rt).
REQ-021 Operator codes SHALL be OR 8'h0D, AND 8'h0C, XOR 8'h0E, NOR 8'h27; logic ops category 1.
REQ-022 Unrecognised encodings, including all-zero, SHALL load a bubble (all outputs zero).
REQ-023 Source value SHALL be: register 0 reads 0; else EX forward (held output destination_write_enable=1, category 1, result_address match, value ex_result); else MEM forward (mem_write_enable=1, address match); else register file.
REQ-024 Load-use hazard: held output category 2, destination_write_enable 1, result_address nonzero and equal to a source register actually used by the decoded instruction.
REQ-025 instruction_ready SHALL equal instruction_valid AND NOT hold AND NOT hazard AND NOT reset.
REQ-026 Each edge, in priority order: reset or flush -> load bubble; hold -> keep register; hazard -> load bubble, instruction not consumed; instruction_valid -> load decoded instruction; else -> load bubble.
REQ-027 Latency SHALL be one cycle from consumed instruction to registered outputs; throughput one per cycle absent stalls.
REQ-028 A hazard SHALL cost exactly one bubble; the stalled instruction re-decodes next cycle using MEM forwarding.
REQ-029 flush during hold SHALL still empty the register; flush during hazard SHALL not consume the instruction.

Reset
REQ-030 While reset is high, all registered outputs SHALL be zero at the next edge and instruction_ready SHALL be 0.
REQ-031 Reset asserted mid-stall SHALL clear hazard state; the first post-reset instruction SHALL decode without a bubble.

Verification
REQ-032 ORI $1,$0,0x1234 -> next cycle category 1, operator 8'h0D, operand_a 0, operand_b 32'h00001234, result_address 1, destination_write_enable 1.
REQ-033 OR $3,$1,$2 right after ORI $1 with ex_result 32'hFFFF0000, register_data_b 32'h0000FFFF -> operand_a 32'hFFFF0000, operand_b 32'h0000FFFF.
REQ-034 LW $4,8($5) then ORI $6,$4,1 -> instruction_ready 0 one cycle, one bubble, then ORI with operand_a = mem_write_data.
REQ-035 hold high for 3 cycles with valid instructions -> outputs unchanged, instruction_ready 0, nothing lost after release.
REQ-036 flush with hold high -> all outputs 0 next cycle; LUI $7,0xABCD -> operand_a 32'hABCD0000, operand_b 0.

Source files
------------

// File: rtl/stage_id.sv
// Instruction decode stage for a MIPS logic/load subset: decodes, forwards
// operands from EX/MEM, detects load-use hazards and registers the result.
module stage_id (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        flush_i,
  input  logic        hold_i,
  input  logic        instruction_valid_i,
  input  logic [31:0] instruction_i,
  output logic        instruction_ready_o,
  output logic [4:0]  register_address_a_o,
  output logic [4:0]  register_address_b_o,
  input  logic [31:0] register_data_a_i,
  input  logic [31:0] register_data_b_i,
  input  logic [31:0] ex_result_i,
  input  logic        mem_write_enable_i,
  input  logic [4:0]  mem_write_address_i,
  input  logic [31:0] mem_write_data_i,
  output logic [2:0]  category_o,
  output logic [7:0]  operator_o,
  output logic [31:0] operand_a_o,
  output logic [31:0] operand_b_o,
  output logic [4:0]  result_address_o,
  output logic        destination_write_enable_o
);

  localparam logic [2:0] CAT_LOGIC = 3'd1;
  localparam logic [2:0] CAT_LOAD  = 3'd2;

  localparam logic [7:0] OP_OR  = 8'h0D;
  localparam logic [7:0] OP_AND = 8'h0C;
  localparam logic [7:0] OP_XOR = 8'h0E;
  localparam logic [7:0] OP_NOR = 8'h27;
  localparam logic [7:0] OP_LW  = 8'h23;

  localparam logic [5:0] OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] OPC_ORI     = 6'b001101;
  localparam logic [5:0] OPC_ANDI    = 6'b001100;
  localparam logic [5:0] OPC_XORI    = 6'b001110;
  localparam logic [5:0] OPC_LUI     = 6'b001111;
  localparam logic [5:0] OPC_LW      = 6'b100011;

  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;

  typedef struct packed {
    logic [2:0]  category;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dst;
    logic        we;
  } id_out_t;

  id_out_t out_q, out_d, dec;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [31:0] src_a, src_b;
  logic        uses_rs, uses_rt, hazard;
  logic        r_ok;
  logic [7:0]  r_op;
  logic        unused_shamt;

  assign opcode = instruction_i[31:26];
  assign rs     = instruction_i[25:21];
  assign rt     = instruction_i[20:16];
  assign rd     = instruction_i[15:11];
  assign funct  = instruction_i[5:0];
  assign imm    = instruction_i[15:0];
  assign unused_shamt = ^instruction_i[10:6];

  assign register_address_a_o = rs;
  assign register_address_b_o = rt;

  // Operand source: $0, then EX result of the held logic op, then MEM writeback, then register file.
  assign src_a = (rs == 5'd0) ? 32'd0 :
                 (out_q.we && out_q.category == CAT_LOGIC && out_q.dst == rs) ? ex_result_i :
                 (mem_write_enable_i && mem_write_address_i == rs) ? mem_write_data_i :
                 register_data_a_i;
  assign src_b = (rt == 5'd0) ? 32'd0 :
                 (out_q.we && out_q.category == CAT_LOGIC && out_q.dst == rt) ? ex_result_i :
                 (mem_write_enable_i && mem_write_address_i == rt) ? mem_write_data_i :
                 register_data_b_i;

  always_comb begin
    r_ok = 1'b1;
    r_op = 8'h00;
    case (funct)
      FN_OR:   r_op = OP_OR;
      FN_AND:  r_op = OP_AND;
      FN_XOR:  r_op = OP_XOR;
      FN_NOR:  r_op = OP_NOR;
      default: r_ok = 1'b0;
    endcase
  end

  // Decode; anything not recognised stays an all-zero bubble.
  always_comb begin
    dec     = '0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    case (opcode)
      OPC_SPECIAL: begin
        if (r_ok) begin
          dec.category = CAT_LOGIC;
          dec.op       = r_op;
          dec.a        = src_a;
          dec.b        = src_b;
          dec.dst      = rd;
          dec.we       = 1'b1;
          uses_rs      = 1'b1;
          uses_rt      = 1'b1;
        end
      end
      OPC_ORI, OPC_ANDI, OPC_XORI: begin
        dec.category = CAT_LOGIC;
        dec.op       = (opcode == OPC_ORI) ? OP_OR : (opcode == OPC_ANDI) ? OP_AND : OP_XOR;
        dec.a        = src_a;
        dec.b        = {16'h0000, imm};
        dec.dst      = rt;
        dec.we       = 1'b1;
        uses_rs      = 1'b1;
      end
      OPC_LUI: begin
        dec.category = CAT_LOGIC;
        dec.op       = OP_OR;
        dec.a        = {imm, 16'h0000};
        dec.b        = 32'd0;
        dec.dst      = rt;
        dec.we       = 1'b1;
      end
      OPC_LW: begin
        dec.category = CAT_LOAD;
        dec.op       = OP_LW;
        dec.a        = src_a;
        dec.b        = {{16{imm[15]}}, imm};
        dec.dst      = rt;
        dec.we       = 1'b1;
        uses_rs      = 1'b1;
      end
      default: dec = '0;
    endcase
  end

  // A held load cannot forward its data yet, so a dependent consumer waits one cycle.
  assign hazard = instruction_valid_i && out_q.we && (out_q.category == CAT_LOAD) &&
                  (out_q.dst != 5'd0) &&
                  ((uses_rs && out_q.dst == rs) || (uses_rt && out_q.dst == rt));

  assign instruction_ready_o = instruction_valid_i && !hold_i && !hazard && !reset_i;

  always_comb begin
    out_d = out_q;
    if (reset_i || flush_i)    out_d = '0;
    else if (hold_i)           out_d = out_q;
    else if (hazard)           out_d = '0;
    else if (instruction_valid_i) out_d = dec;
    else                       out_d = '0;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) out_q <= '0;
    else         out_q <= out_d;
  end

  assign category_o                 = out_q.category;
  assign operator_o                 = out_q.op;
  assign operand_a_o                = out_q.a;
  assign operand_b_o                = out_q.b;
  assign result_address_o           = out_q.dst;
  assign destination_write_enable_o = out_q.we;

endmodule

// File: tb/tb_stage_id.sv
// Randomized bench for stage_id against an instruction-level reference model.
module tb_stage_id;

  logic        clock = 1'b0;
  logic        reset, flush, hold, ivalid;
  logic [31:0] instr;
  logic        ready;
  logic [4:0]  addr_a, addr_b;
  logic [31:0] rdata_a, rdata_b;
  logic [31:0] ex_result;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic [2:0]  category;
  logic [7:0]  operator_v;
  logic [31:0] opa, opb;
  logic [4:0]  res_addr;
  logic        dwe;

  logic [31:0] regs [32];

  int n_checks = 0;
  int n_errors = 0;
  logic dut_ready;

  typedef struct packed {
    logic [2:0]  cat;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dst;
    logic        we;
  } exp_t;

  exp_t m_q;

  always #5 clock = ~clock;

  assign rdata_a = regs[addr_a];
  assign rdata_b = regs[addr_b];

  stage_id dut (
    .clock_i                    (clock),
    .reset_i                    (reset),
    .flush_i                    (flush),
    .hold_i                     (hold),
    .instruction_valid_i        (ivalid),
    .instruction_i              (instr),
    .instruction_ready_o        (ready),
    .register_address_a_o       (addr_a),
    .register_address_b_o       (addr_b),
    .register_data_a_i          (rdata_a),
    .register_data_b_i          (rdata_b),
    .ex_result_i                (ex_result),
    .mem_write_enable_i         (mem_we),
    .mem_write_address_i        (mem_addr),
    .mem_write_data_i           (mem_data),
    .category_o                 (category),
    .operator_o                 (operator_v),
    .operand_a_o                (opa),
    .operand_b_o                (opb),
    .result_address_o           (res_addr),
    .destination_write_enable_o (dwe)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    return {6'h00, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] s, input logic [4:0] t, input logic [15:0] im);
    return {opc, s, t, im};
  endfunction

  // Value an instruction sees for register r, given what is in flight.
  function automatic logic [31:0] srcval(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (m_q.we && m_q.cat == 3'd1 && m_q.dst == r) return ex_result;
    if (mem_we && mem_addr == r) return mem_data;
    return regs[r];
  endfunction

  function automatic exp_t m_decode(input logic [31:0] w, output logic use_rs, output logic use_rt);
    exp_t e;
    logic [5:0] opc, fn;
    logic [4:0] s, t, d;
    logic [15:0] im;
    opc = w[31:26]; fn = w[5:0]; s = w[25:21]; t = w[20:16]; d = w[15:11]; im = w[15:0];
    e = '0; use_rs = 1'b0; use_rt = 1'b0;
    if (opc == 6'h00 && (fn == 6'h25 || fn == 6'h24 || fn == 6'h26 || fn == 6'h27)) begin
      e.cat = 3'd1;
      e.op  = (fn == 6'h25) ? 8'h0D : (fn == 6'h24) ? 8'h0C : (fn == 6'h26) ? 8'h0E : 8'h27;
      e.a = srcval(s); e.b = srcval(t); e.dst = d; e.we = 1'b1;
      use_rs = 1'b1; use_rt = 1'b1;
    end else if (opc == 6'h0D || opc == 6'h0C || opc == 6'h0E) begin
      e.cat = 3'd1; e.op = {2'b00, opc};
      e.a = srcval(s); e.b = {16'h0, im}; e.dst = t; e.we = 1'b1;
      use_rs = 1'b1;
    end else if (opc == 6'h0F) begin
      e.cat = 3'd1; e.op = 8'h0D; e.a = {im, 16'h0}; e.b = 32'd0; e.dst = t; e.we = 1'b1;
    end else if (opc == 6'h23) begin
      e.cat = 3'd2; e.op = 8'h23;
      e.a = srcval(s); e.b = 32'($signed(im)); e.dst = t; e.we = 1'b1;
      use_rs = 1'b1;
    end
    return e;
  endfunction

  task automatic step(input logic r, input logic f, input logic h, input logic v, input logic [31:0] ins);
    exp_t dec, nxt;
    logic urs, urt, haz, m_ready;
    @(negedge clock);
    reset = r; flush = f; hold = h; ivalid = v; instr = ins;
    #1;
    dec = m_decode(ins, urs, urt);
    haz = v && m_q.we && m_q.cat == 3'd2 && m_q.dst != 5'd0 &&
          ((urs && m_q.dst == ins[25:21]) || (urt && m_q.dst == ins[20:16]));
    m_ready = v && !h && !haz && !r;
    dut_ready = ready;
    chk("ready", 32'(ready), 32'(m_ready));
    chk("addr_a", 32'(addr_a), 32'(ins[25:21]));
    chk("addr_b", 32'(addr_b), 32'(ins[20:16]));
    if (r || f)      nxt = '0;
    else if (h)      nxt = m_q;
    else if (haz)    nxt = '0;
    else if (v)      nxt = dec;
    else             nxt = '0;
    @(posedge clock);
    #1;
    m_q = nxt;
    chk("category", 32'(category), 32'(m_q.cat));
    chk("operator", 32'(operator_v), 32'(m_q.op));
    chk("operand_a", opa, m_q.a);
    chk("operand_b", opb, m_q.b);
    chk("result_address", 32'(res_addr), 32'(m_q.dst));
    chk("dest_we", 32'(dwe), 32'(m_q.we));
  endtask

  function automatic logic [31:0] rand_instr();
    int k;
    logic [4:0] s, t, d;
    k = $urandom_range(0, 9);
    s = 5'($urandom_range(0, 7)); t = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 7));
    case (k)
      0: return enc_r(6'h25, s, t, d);
      1: return enc_r(6'h24, s, t, d);
      2: return enc_r(6'h26, s, t, d);
      3: return enc_r(6'h27, s, t, d);
      4: return enc_i(6'h0D, s, t, 16'($urandom));
      5: return enc_i(6'h0C, s, t, 16'($urandom));
      6: return enc_i(6'h0E, s, t, 16'($urandom));
      7: return enc_i(6'h0F, s, t, 16'($urandom));
      8: return enc_i(6'h23, s, t, 16'($urandom));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] pend;
    logic        pend_v;
    m_q = '0;
    reset = 1'b1; flush = 1'b0; hold = 1'b0; ivalid = 1'b0; instr = 32'd0;
    ex_result = 32'd0; mem_we = 1'b0; mem_addr = 5'd0; mem_data = 32'd0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[2] = 32'h0000FFFF;

    // Reset, including a valid instruction offered during reset
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, enc_i(6'h0D, 5'd0, 5'd1, 16'h1));
    chk("reset_ready", 32'(dut_ready), 32'd0);
    chk("reset_we", 32'(dwe), 32'd0);

    // ORI $1,$0,0x1234
    step(1'b0, 1'b0, 1'b0, 1'b1, enc_i(6'h0D, 5'd0, 5'd1, 16'h1234));
    chk("ori_cat", 32'(category), 32'd1);
    chk("ori_op", 32'(operator_v), 32'h0D);
    chk("ori_a", opa, 32'd0);
    chk("ori_b", opb, 32'h00001234);
    chk("ori_dst", 32'(res_addr), 32'd1);
    chk("ori_we", 32'(dwe), 32'd1);

    // OR $3,$1,$2 forwarding $1 from EX
    ex_result = 32'hFFFF0000;
    step(1'b0, 1'b0, 1'b0, 1'b1, enc_r(6'h25, 5'd1, 5'd2, 5'd3));
    chk("or_a", opa, 32'hFFFF0000);
    chk("or_b", opb, 32'h0000FFFF);
    chk("or_dst", 32'(res_addr), 32'd3);

    // LW $4,8($5) then dependent ORI $6,$4,1
    step(1'b0, 1'b0, 1'b0, 1'b1, enc_i(6'h23, 5'd5, 5'd4, 16'd8));
    chk("lw_cat", 32'(category), 32'd2);
    chk("lw_b", opb, 32'd8);
    step(1'b0, 1'b0, 1'b0, 1'b1, enc_i(6'h0D, 5'd4, 5'd6, 16'd1));
    chk("lu_ready", 32'(dut_ready), 32'd0);
    chk("lu_bubble", 32'(dwe), 32'd0);
    mem_we = 1'b1; mem_addr = 5'd4; mem_data = 32'hCAFE0004;
    step(1'b0, 1'b0, 1'b0, 1'b1, enc_i(6'h0D, 5'd4, 5'd6, 16'd1));
    chk("lu_ready2", 32'(dut_ready), 32'd1);
    chk("lu_a", opa, 32'hCAFE0004);
    chk("lu_b", opb, 32'd1);
    mem_we = 1'b0;

    // Hold for three cycles, then release the same instruction
    step(1'b0, 1'b0, 1'b1, 1'b1, enc_i(6'h0E, 5'd3, 5'd7, 16'h00F0));
    step(1'b0, 1'b0, 1'b1, 1'b1, enc_i(6'h0E, 5'd3, 5'd7, 16'h00F0));
    step(1'b0, 1'b0, 1'b1, 1'b1, enc_i(6'h0E, 5'd3, 5'd7, 16'h00F0));
    chk("hold_a", opa, 32'hCAFE0004);
    chk("hold_ready", 32'(dut_ready), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, enc_i(6'h0E, 5'd3, 5'd7, 16'h00F0));
    chk("hold_rel_b", opb, 32'h000000F0);
    chk("hold_rel_dst", 32'(res_addr), 32'd7);

    // Flush during hold empties the register; then LUI
    step(1'b0, 1'b1, 1'b1, 1'b1, enc_i(6'h0D, 5'd0, 5'd1, 16'h5));
    chk("flush_we", 32'(dwe), 32'd0);
    chk("flush_a", opa, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, enc_i(6'h0F, 5'd0, 5'd7, 16'hABCD));
    chk("lui_a", opa, 32'hABCD0000);
    chk("lui_b", opb, 32'd0);

    // Reset during a load-use stall: next instruction decodes immediately
    step(1'b0, 1'b0, 1'b0, 1'b1, enc_i(6'h23, 5'd5, 5'd4, 16'd8));
    step(1'b1, 1'b0, 1'b0, 1'b1, enc_i(6'h0D, 5'd4, 5'd6, 16'd1));
    step(1'b0, 1'b0, 1'b0, 1'b1, enc_i(6'h0D, 5'd4, 5'd6, 16'd1));
    chk("rst_stall_ready", 32'(dut_ready), 32'd1);
    chk("rst_stall_a", opa, regs[4]);

    // Randomized traffic; an unconsumed instruction is offered again
    pend = rand_instr(); pend_v = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic r, f, h, v;
      ex_result = $urandom;
      mem_we    = 1'($urandom_range(0, 1));
      mem_addr  = 5'($urandom_range(0, 7));
      mem_data  = $urandom;
      r = ($urandom_range(0, 99) < 2);
      f = ($urandom_range(0, 99) < 5);
      h = ($urandom_range(0, 99) < 15);
      v = pend_v;
      step(r, f, h, v, pend);
      if (!v || dut_ready) begin
        pend   = rand_instr();
        pend_v = ($urandom_range(0, 99) < 85);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
